// File: rtl/deserializer_if.sv
// Serial-in / parallel-out bus bundle for the deserializer.
// The slave modport is the deserializer; the master modport is the serial
// source that also consumes the recovered words.
interface deserializer_if #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DATA_MOD_W = 4
);
    logic                  ser_data_i;
    logic                  ser_data_val_i;
    logic [DATA_W-1:0]     deser_data_o;
    logic [DATA_MOD_W-1:0] deser_data_mod_o;
    logic                  deser_data_val_o;
    logic                  busy_o;

    modport slave (
        input  ser_data_i,
        input  ser_data_val_i,
        output deser_data_o,
        output deser_data_mod_o,
        output deser_data_val_o,
        output busy_o
    );

    modport master (
        output ser_data_i,
        output ser_data_val_i,
        input  deser_data_o,
        input  deser_data_mod_o,
        input  deser_data_val_o,
        input  busy_o
    );
endinterface

// File: rtl/deserializer.sv
// Serial-to-parallel deserializer: collects an MSB-first bit stream into
// DATA_W-bit words and emits each word with a one-cycle valid pulse.
// Optional feature macro: DESERIALIZER_TIMEOUT_EN -- flush a partial word
// (with its bit count in deser_data_mod_o) after IDLE_TIMEOUT idle cycles.
module deserializer #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned DATA_MOD_W   = 4,
    parameter int unsigned IDLE_TIMEOUT = 8
) (
    input  logic            clk_i,
    input  logic            arst_n_i,
    deserializer_if.slave   bus
);

    localparam int unsigned CNT_W  = DATA_MOD_W;
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

`ifdef DESERIALIZER_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    // Bit counter doubles as the IDLE (0) / COLLECT (!=0) state
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [IDLE_W-1:0]     idle_q,  idle_d;
    logic [DATA_W-1:0]     data_q,  data_d;
    logic [DATA_MOD_W-1:0] mod_q,   mod_d;
    logic                  val_q,   val_d;
    logic                  busy_q,  busy_d;

    // Buffer position of the incoming bit: first bit lands in the MSB
    logic [CNT_W-1:0]      bit_idx_c;
    assign bit_idx_c = CNT_LAST - cnt_q;

    // Next-state: accept a bit, complete a word, or count idle toward a flush
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        idle_d  = idle_q;
        data_d  = data_q;
        mod_d   = mod_q;
        val_d   = 1'b0;

        if (bus.ser_data_val_i) begin
            // A valid bit always wins, including on the would-be flush edge
            shift_d[bit_idx_c] = bus.ser_data_i;
            idle_d             = '0;
            if (cnt_q == CNT_LAST) begin
                data_d  = shift_d;
                mod_d   = '0;
                val_d   = 1'b1;
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (TIMEOUT_EN && (cnt_q != '0)) begin
            // Idle counter runs only while a partial word is held
            if (idle_q == IDLE_LAST) begin
                data_d  = shift_q;
                mod_d   = cnt_q;
                val_d   = 1'b1;
                shift_d = '0;
                cnt_d   = '0;
                idle_d  = '0;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end

        busy_d = (cnt_d != '0);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
            idle_q  <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idle_q  <= idle_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.deser_data_o     = data_q;
    assign bus.deser_data_mod_o = mod_q;
    assign bus.deser_data_val_o = val_q;
    assign bus.busy_o           = busy_q;

endmodule
